// File: rtl/ram8_arbiter.sv
// ram8_arbiter: two-requester arbiter in front of a single-port RAM8.
// Each access takes three cycles (IDLE sample, ACCESS, RESP). gnt0/gnt1 pulse
// during ACCESS and done/done_id pulse during RESP.
// Optional feature: define ROUND_ROBIN_EN to alternate between requesters
// when both request together. Without it, requester 0 always has priority.
module ram8_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done,
  output logic              done_id,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q;
  logic                gnt0_q;
  logic                gnt1_q;
  logic                done_q;
  logic                done_id_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [DATA_W-1:0]   rdata_q;
`ifdef ROUND_ROBIN_EN
  logic                last_q;
`endif

  logic                win1_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   din_d;

  // Select the winning requester and mux its operands for capture in IDLE.
  always_comb begin
    win1_d = 1'b0;
    if (req0 && req1) begin
`ifdef ROUND_ROBIN_EN
      win1_d = (last_q == 1'b0);
`else
      win1_d = 1'b0;
`endif
    end else if (req1) begin
      win1_d = 1'b1;
    end else begin
      win1_d = 1'b0;
    end
    we_d   = win1_d ? we1   : we0;
    addr_d = win1_d ? addr1 : addr0;
    din_d  = win1_d ? din1  : din0;
  end

  // Arbitration FSM with all pulses, latched operands and read data registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      din_q     <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
`ifdef ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (req0 || req1) begin
            state_q <= ACCESS;
            owner_q <= win1_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            gnt0_q  <= ~win1_d;
            gnt1_q  <= win1_d;
`ifdef ROUND_ROBIN_EN
            last_q  <= win1_d;
`endif
          end else begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
          end
        end
        ACCESS: begin
          state_q   <= RESP;
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          done_q    <= 1'b1;
          done_id_q <= owner_q;
          if (!we_q) begin
            rdata_q <= ram_out;
          end else begin
            rdata_q <= rdata_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_in   = din_q;
  // A write in progress is aborted the moment reset is raised.
  assign ram_load = (state_q == ACCESS) && we_q && !reset;

endmodule
